// File: rtl/pc_pkg.sv
// pc_unit shared definitions
// op encodings for the program-counter unit
package pc_pkg;

  typedef logic [1:0] pc_op_t;

  localparam pc_op_t OP_SEQ  = 2'b00;
  localparam pc_op_t OP_JUMP = 2'b01;
  localparam pc_op_t OP_CALL = 2'b10;
  localparam pc_op_t OP_RET  = 2'b11;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit control/status bundle
// master = fetch control, slave = pc_unit
interface pc_if #(
  parameter int WIDTH = 32
) ();
  import pc_pkg::*;

  logic             ena;
  pc_op_t           op;
  logic [WIDTH-1:0] target;
  logic             err_clr;
  logic [WIDTH-1:0] pc_out;
  logic             ras_full;
  logic             ras_empty;
  logic             err;

  modport master (
    output ena, op, target, err_clr,
    input  pc_out, ras_full, ras_empty, err
  );

  modport slave (
    input  ena, op, target, err_clr,
    output pc_out, ras_full, ras_empty, err
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack
// Push on full overwrites the oldest entry
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CMAX = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [AW-1:0]    r_tp;
  logic [CW-1:0]    r_cnt;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_cnt == CMAX);
  assign w_empty = (r_cnt == '0);
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_top   = r_mem[r_tp];
  assign o_ovf   = i_push && w_full;
  assign o_unf   = i_pop && w_empty;

  // top pointer wraps; count saturates at both ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tp  <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_tp <= r_tp + 1'b1;
      if (!w_full) r_cnt <= r_cnt + 1'b1;
    end else if (i_pop && !w_empty) begin
      r_tp  <= r_tp - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // entry storage; only read while count is non-zero
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tp + 1'b1] <= i_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit
// PC register, next-PC mux, RAS and sticky error
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  pc_if.slave  bus
);

  logic [WIDTH-1:0] r_pc;
  logic             r_err;
  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_top;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf;
  logic             w_unf;

  assign w_seq  = r_pc + WIDTH'(STEP);
  assign w_push = bus.ena && (bus.op == OP_CALL);
  assign w_pop  = bus.ena && (bus.op == OP_RET);

  pc_ras #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (w_seq),
    .o_top  (w_top),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_ovf  (w_ovf),
    .o_unf  (w_unf)
  );

  // next-PC select; RET on empty stack falls through
  always_comb begin
    w_pc_nxt = w_seq;
    unique case (bus.op)
      OP_SEQ:  w_pc_nxt = w_seq;
      OP_JUMP: w_pc_nxt = bus.target;
      OP_CALL: w_pc_nxt = bus.target;
      OP_RET:  w_pc_nxt = w_empty ? w_seq : w_top;
    endcase
  end

  // PC register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_pc <= RESET_VEC;
    else if (bus.ena) r_pc <= w_pc_nxt;
  end

  // sticky error; a new event beats a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               r_err <= 1'b0;
    else if (w_ovf || w_unf) r_err <= 1'b1;
    else if (bus.err_clr)    r_err <= 1'b0;
  end

  assign bus.pc_out    = r_pc;
  assign bus.ras_full  = w_full;
  assign bus.ras_empty = w_empty;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_pc_unit.sv
// pc_unit bench: directed table, corner sequences,
// random ops against a queue-based reference model
module tb_pc_unit;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  pc_if #(.WIDTH(32)) if_a ();
  pc_if #(.WIDTH(8))  if_b ();

  pc_unit #(
    .WIDTH    (32),
    .RESET_VEC(32'h0000_0100),
    .STEP     (4),
    .RAS_DEPTH(4)
  ) u_a (
    .clk(clk),
    .rst(rst_a),
    .bus(if_a)
  );

  pc_unit #(
    .WIDTH    (8),
    .RESET_VEC(8'hF0),
    .STEP     (4),
    .RAS_DEPTH(2)
  ) u_b (
    .clk(clk),
    .rst(rst_b),
    .bus(if_b)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // reference model: stack as a queue, newest at the back
  logic [31:0] m_pc;
  bit          m_err;
  logic [31:0] m_stk[$];

  task automatic m_reset();
    m_pc  = 32'h100;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic m_step(bit en, logic [1:0] op, logic [31:0] tg, bit clr);
    bit ev;
    ev = 1'b0;
    if (en) begin
      case (op)
        OP_SEQ:  m_pc = m_pc + 32'd4;
        OP_JUMP: m_pc = tg;
        OP_CALL: begin
          if (m_stk.size() == 4) begin
            void'(m_stk.pop_front());
            ev = 1'b1;
          end
          m_stk.push_back(m_pc + 32'd4);
          m_pc = tg;
        end
        default: begin
          if (m_stk.size() == 0) begin
            m_pc = m_pc + 32'd4;
            ev = 1'b1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
      endcase
    end
    if (ev)       m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic run_a(bit en, logic [1:0] op, logic [31:0] tg, bit clr);
    if_a.ena     = en;
    if_a.op      = op;
    if_a.target  = tg;
    if_a.err_clr = clr;
    @(posedge clk);
    m_step(en, op, tg, clr);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_pc"}, if_a.pc_out, m_pc);
    chk({tag, "_err"}, {31'b0, if_a.err}, {31'b0, m_err});
    chk({tag, "_full"}, {31'b0, if_a.ras_full},
        {31'b0, m_stk.size() == 4});
    chk({tag, "_empty"}, {31'b0, if_a.ras_empty},
        {31'b0, m_stk.size() == 0});
  endtask

  task automatic run_b(logic [1:0] op, logic [7:0] tg);
    if_b.ena     = 1'b1;
    if_b.op      = op;
    if_b.target  = tg;
    if_b.err_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          ena;
    logic [1:0]  op;
    logic [31:0] tgt;
    bit          clr;
    logic [31:0] pc;
    bit          err;
    bit          full;
    bit          empty;
  } vec_t;

  function automatic vec_t mk(bit en, logic [1:0] op, logic [31:0] tg,
                              bit clr, logic [31:0] pc, bit err,
                              bit full, bit empty);
    vec_t v;
    v.ena = en; v.op = op; v.tgt = tg; v.clr = clr;
    v.pc = pc; v.err = err; v.full = full; v.empty = empty;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    bit          en;
    bit          clr;
    logic [1:0]  op;
    logic [31:0] tg;

    // stall, call/return, overflow, underflow, clear, wrap
    repeat (3) tbl.push_back(mk(0, OP_JUMP, 32'hFF, 0, 32'h100, 0, 0, 1));
    tbl.push_back(mk(1, OP_JUMP, 32'hFF,  0, 32'hFF,  0, 0, 1));
    tbl.push_back(mk(1, OP_JUMP, 32'h200, 0, 32'h200, 0, 0, 1));
    tbl.push_back(mk(1, OP_CALL, 32'h800, 0, 32'h800, 0, 0, 0));
    tbl.push_back(mk(1, OP_SEQ,  32'h0,   0, 32'h804, 0, 0, 0));
    tbl.push_back(mk(1, OP_RET,  32'h0,   0, 32'h204, 0, 0, 1));
    tbl.push_back(mk(1, OP_JUMP, 32'h0,   0, 32'h0,   0, 0, 1));
    tbl.push_back(mk(1, OP_CALL, 32'h10,  0, 32'h10,  0, 0, 0));
    tbl.push_back(mk(1, OP_CALL, 32'h20,  0, 32'h20,  0, 0, 0));
    tbl.push_back(mk(1, OP_CALL, 32'h30,  0, 32'h30,  0, 0, 0));
    tbl.push_back(mk(1, OP_CALL, 32'h40,  0, 32'h40,  0, 1, 0));
    tbl.push_back(mk(1, OP_CALL, 32'h50,  0, 32'h50,  1, 1, 0));
    tbl.push_back(mk(1, OP_RET,  32'h0,   0, 32'h44,  1, 0, 0));
    tbl.push_back(mk(1, OP_RET,  32'h0,   0, 32'h34,  1, 0, 0));
    tbl.push_back(mk(1, OP_RET,  32'h0,   0, 32'h24,  1, 0, 0));
    tbl.push_back(mk(1, OP_RET,  32'h0,   0, 32'h14,  1, 0, 1));
    tbl.push_back(mk(1, OP_RET,  32'h0,   0, 32'h18,  1, 0, 1));
    tbl.push_back(mk(0, OP_RET,  32'h0,   1, 32'h18,  0, 0, 1));
    tbl.push_back(mk(1, OP_RET,  32'h0,   1, 32'h1C,  1, 0, 1));
    tbl.push_back(mk(0, OP_SEQ,  32'h0,   1, 32'h1C,  0, 0, 1));
    tbl.push_back(mk(1, OP_CALL, 32'h300, 0, 32'h300, 0, 0, 0));
    tbl.push_back(mk(1, OP_RET,  32'h0,   0, 32'h20,  0, 0, 1));
    tbl.push_back(mk(1, OP_JUMP, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 0, 1));
    tbl.push_back(mk(1, OP_SEQ,  32'h0,   0, 32'h0,   0, 0, 1));

    if_a.ena = 1'b0; if_a.op = OP_SEQ; if_a.target = '0; if_a.err_clr = 1'b0;
    if_b.ena = 1'b0; if_b.op = OP_SEQ; if_b.target = '0; if_b.err_clr = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", if_a.pc_out, 32'h100);
    chk("rst_empty", {31'b0, if_a.ras_empty}, 32'd1);
    chk("rst_full", {31'b0, if_a.ras_full}, 32'd0);
    chk("rst_err", {31'b0, if_a.err}, 32'd0);
    chk("rst_b_pc", {24'b0, if_b.pc_out}, 32'hF0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    m_reset();

    // first ops act on the reset vector
    run_a(1, OP_SEQ, 32'h0, 0);
    chk("seq1", if_a.pc_out, 32'h104);
    run_a(1, OP_SEQ, 32'h0, 0);
    chk("seq2", if_a.pc_out, 32'h108);
    run_a(1, OP_SEQ, 32'h0, 0);
    chk("seq3", if_a.pc_out, 32'h10C);
    run_a(1, OP_CALL, 32'h400, 0);
    chk("call_pre_rst", if_a.pc_out, 32'h400);
    chk("call_pre_rst_empty", {31'b0, if_a.ras_empty}, 32'd0);

    // asynchronous reset mid-run, no clock edge
    rst_a = 1'b0;
    #1;
    chk("async_rst_pc", if_a.pc_out, 32'h100);
    chk("async_rst_empty", {31'b0, if_a.ras_empty}, 32'd1);
    rst_a = 1'b1;
    m_reset();

    foreach (tbl[i]) begin
      run_a(tbl[i].ena, tbl[i].op, tbl[i].tgt, tbl[i].clr);
      chk($sformatf("v%0d_pc", i), if_a.pc_out, tbl[i].pc);
      chk($sformatf("v%0d_err", i), {31'b0, if_a.err}, {31'b0, tbl[i].err});
      chk($sformatf("v%0d_full", i), {31'b0, if_a.ras_full},
          {31'b0, tbl[i].full});
      chk($sformatf("v%0d_empty", i), {31'b0, if_a.ras_empty},
          {31'b0, tbl[i].empty});
    end
    if_a.ena = 1'b0;
    if_a.err_clr = 1'b0;

    // 8-bit instance: wrap of SEQ and of pushed return address
    run_b(OP_JUMP, 8'hFC);
    chk("b_jump", {24'b0, if_b.pc_out}, 32'hFC);
    run_b(OP_SEQ, 8'h00);
    chk("b_wrap", {24'b0, if_b.pc_out}, 32'h00);
    chk("b_wrap_err", {31'b0, if_b.err}, 32'd0);
    run_b(OP_JUMP, 8'hFC);
    run_b(OP_CALL, 8'h10);
    chk("b_call", {24'b0, if_b.pc_out}, 32'h10);
    run_b(OP_RET, 8'h00);
    chk("b_ret_wrap", {24'b0, if_b.pc_out}, 32'h00);
    chk("b_ret_empty", {31'b0, if_b.ras_empty}, 32'd1);
    chk("b_ret_err", {31'b0, if_b.err}, 32'd0);
    if_b.ena = 1'b0;

    // random ops against the model
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      op  = 2'($urandom_range(0, 3));
      tg  = $urandom;
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) begin
        rst_a = 1'b0;
        #1;
        m_reset();
        chk("rnd_rst_pc", if_a.pc_out, m_pc);
        rst_a = 1'b1;
      end
      run_a(en, op, tg, clr);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit, successor to the plain 32-bit PC register. Adds configurable width, reset vector and step, plus sequential/jump/call/return modes backed by a small return-address stack (RAS). Sits at the head of the fetch stage; `pc_out` drives the instruction-memory address, and control logic drives `op`/`target`.

## Interface
- `WIDTH`, 32: PC and target width in bits; ≥ 8.
- `RESET_VEC`, 0: PC value after reset; WIDTH bits.
- `STEP`, 4: sequential increment; fits in WIDTH bits.
- `RAS_DEPTH`, 4: return-address stack entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  advance enable; 0 = stall, all state held.
- `op`  in  2  00 SEQ, 01 JUMP, 10 CALL, 11 RET.
- `target`  in  WIDTH  jump/call destination.
- `err_clr`  in  1  clears sticky `err`.
- `pc_out`  out  WIDTH  current PC (registered).
- `ras_full`  out  1  RAS holds RAS_DEPTH entries.
- `ras_empty`  out  1  RAS holds 0 entries.
- `err`  out  1  sticky RAS overflow/underflow flag.

## Operation
- Reset (`rst`=0, any time, asynchronous): `pc_out`=RESET_VEC, RAS count=0 (`ras_empty`=1, `ras_full`=0), `err`=0. Reset mid-sequence discards all RAS contents.
- `ena`=0: PC, RAS and `err` all held; `op` and `target` ignored. `err_clr` still acts.
- `ena`=1:
  - SEQ: pc ← pc + STEP.
  - JUMP: pc ← target.
  - CALL: push (pc + STEP), then pc ← target. If RAS is full, the oldest entry is overwritten (circular), count stays RAS_DEPTH, and `err` is set.
  - RET: pc ← top entry, then pop. If RAS is empty, pc ← pc + STEP, count stays 0, and `err` is set.
- Arithmetic: pc + STEP is modulo 2^WIDTH. Wrap from all-ones region to low addresses is legal and raises no flag. `target` is used unmodified; no alignment check.
- `err` is sticky until `err_clr`=1. If an error event and `err_clr` occur in the same cycle, the error wins and `err` reads 1.
- RAS pointers: top-of-stack index wraps modulo RAS_DEPTH. Count saturates at 0 and at RAS_DEPTH.

## Timing
- All updates occur at the rising `clk` edge where `ena`=1. `pc_out` reflects the new value in the next cycle (one-cycle latency from `op`).
- RET reads the RAS entry pushed in any earlier cycle. Back-to-back CALL→RET returns the address pushed by the preceding edge.
- `ras_full`, `ras_empty` and `err` are registered and update on the same edge as the operation that changes them.
- Reset release is sampled by the next rising edge. The first operation acts on RESET_VEC.

## Structure
- Package `pc_pkg`: `op` encoding constants (`OP_SEQ`, `OP_JUMP`, `OP_CALL`, `OP_RET`) and a 2-bit `pc_op_t` typedef.
- Sub-module `pc_ras`: circular return-address stack (WIDTH, RAS_DEPTH).
  - Inputs: push, pop, push data.
  - Outputs: top data, full, empty, overflow and underflow pulses.
- The top level holds the PC register, next-PC multiplexer and sticky error logic.

## Test plan
- Reset and SEQ: `rst` low then high, RESET_VEC=0x0000_0100, STEP=4, three SEQ cycles → `pc_out` 0x100, 0x104, 0x108, 0x10C. Assert `rst` mid-run → `pc_out`=0x100 immediately, without waiting for a clock edge.
- Stall: `ena`=0 for 3 cycles with `op`=JUMP, `target`=0xFF → `pc_out` unchanged. `ena`=1 → 0xFF on the next edge.
- Call/return: pc=0x200, CALL to 0x800, SEQ, RET → `pc_out` 0x800, 0x804, 0x204; `ras_empty` 0→1 after RET; `err`=0.
- Overflow: RAS_DEPTH=4, five nested CALLs from pc 0x0,0x10,0x20,0x30,0x40 (targets 0x10…0x50) → `ras_full`=1, `err`=1. Five RETs → 0x44, 0x34, 0x24, 0x14, then underflow: pc+4, `err` stays 1.
- Error clear: with `err`=1, pulse `err_clr` → `err`=0. Then RET on empty RAS together with `err_clr` → `err`=1.
- Wrap: WIDTH=8, pc=0xFC, SEQ → `pc_out`=0x00, no `err`.
